// File: rtl/speck_cipher_core.sv
// Iterative Speck block cipher, one round per clock, encrypt or decrypt.
// Expanded round keys are cached so repeated use of one key skips expansion.
module speck_cipher_core #(
   parameter int WORD      = 64,
   parameter int KEY_WORDS = 2,
   parameter int ROUNDS    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      decrypt,
   input  logic [KEY_WORDS*WORD-1:0] key,
   input  logic [2*WORD-1:0]         block_in,
   output logic                      ready,
   output logic                      done,
   output logic [2*WORD-1:0]         block_out
);

   localparam int ALPHA = (WORD == 16) ? 7 : 8;
   localparam int BETA  = (WORD == 16) ? 2 : 3;
   localparam int CW    = $clog2(ROUNDS);
   localparam int LW    = KEY_WORDS - 1;
   localparam int KW    = KEY_WORDS * WORD;

   typedef enum logic [1:0] {IDLE, EXPAND, RUN, DONE} state_t;

   state_t            state, state_next;
   logic [CW-1:0]     cnt;
   logic              last;
   logic              hit;
   logic              cache_valid;
   logic [KW-1:0]     cache_key, key_q;
   logic              dec_q;
   logic [WORD-1:0]   x_q, y_q, rk_q;
   logic [WORD-1:0]   l_q [LW];
   logic [WORD-1:0]   rk_file [ROUNDS];
   logic [WORD-1:0]   rk_r, l_new, rk_next;
   logic [WORD-1:0]   enc_x, enc_y, dec_x, dec_y;

   function automatic logic [WORD-1:0] ror_a(input logic [WORD-1:0] v);
      return {v[ALPHA-1:0], v[WORD-1:ALPHA]};
   endfunction

   function automatic logic [WORD-1:0] rol_a(input logic [WORD-1:0] v);
      return {v[WORD-1-ALPHA:0], v[WORD-1:WORD-ALPHA]};
   endfunction

   function automatic logic [WORD-1:0] ror_b(input logic [WORD-1:0] v);
      return {v[BETA-1:0], v[WORD-1:BETA]};
   endfunction

   function automatic logic [WORD-1:0] rol_b(input logic [WORD-1:0] v);
      return {v[WORD-1-BETA:0], v[WORD-1:WORD-BETA]};
   endfunction

   assign last  = (cnt == CW'(ROUNDS - 1));
   assign hit   = cache_valid && (key == cache_key);
   assign ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = hit ? RUN : EXPAND;
         EXPAND:  if (last)  state_next = RUN;
         RUN:     if (last)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Decrypt walks the key schedule backwards over the same counter.
   always_comb begin
      rk_r    = rk_file[dec_q ? (CW'(ROUNDS - 1) - cnt) : cnt];
      l_new   = (rk_q + ror_a(l_q[0])) ^ WORD'(cnt);
      rk_next = rol_b(rk_q) ^ l_new;
      enc_x   = (ror_a(x_q) + y_q) ^ rk_r;
      enc_y   = rol_b(y_q) ^ enc_x;
      dec_y   = ror_b(y_q ^ x_q);
      dec_x   = rol_a((x_q ^ rk_r) - dec_y);
   end

   // NOTE: sequential state is always written with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (state_next != state || state == IDLE || state == DONE) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cache_valid <= 1'b0;
         done        <= 1'b0;
         block_out   <= '0;
      end else begin
         done <= (state == DONE);
         if (state == DONE)          block_out   <= {x_q, y_q};
         if (state == EXPAND && last) cache_valid <= 1'b1;
      end
   end

   // NOTE: the round-key file and working registers carry no reset; control state guards their use.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         dec_q <= decrypt;
         key_q <= key;
         x_q   <= block_in[2*WORD-1:WORD];
         y_q   <= block_in[WORD-1:0];
         rk_q  <= key[WORD-1:0];
         for (int j = 0; j < LW; j++) l_q[j] <= key[(j+1)*WORD +: WORD];
      end else if (state == EXPAND) begin
         rk_file[cnt] <= rk_q;
         rk_q         <= rk_next;
         for (int j = 0; j < LW - 1; j++) l_q[j] <= l_q[j+1];
         l_q[LW-1]    <= l_new;
         if (last) cache_key <= key_q;
      end else if (state == RUN) begin
         x_q <= dec_q ? dec_x : enc_x;
         y_q <= dec_q ? dec_y : enc_y;
      end
   end

endmodule

// File: tb/tb_speck_cipher_core.sv
// Scoreboard bench for speck_cipher_core: Speck128/128 and Speck32/64 instances
// checked against a word-level reference model of the cipher.
module tb_speck_cipher_core;

   localparam int T0 = 32;
   localparam int T1 = 22;

   typedef struct {
      logic [127:0] blk;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start0, dec0, ready0, done0;
   logic [127:0] key0, blk0, out0;
   logic         start1, dec1, ready1, done1;
   logic [63:0]  key1;
   logic [31:0]  blk1, out1;

   int           cyc = 0;
   int           n_checks = 0;
   int           n_pass = 0;
   int           prev_done0 = 0, last_done0 = 0;
   exp_t         q0[$], q1[$];
   logic         c0_valid = 1'b0, c1_valid = 1'b0;
   logic [127:0] c0_key = '0, c1_key = '0;

   localparam logic [127:0] K_A = 128'h0f0e0d0c0b0a0908_0706050403020100;
   localparam logic [127:0] P_A = 128'h6c61766975716520_7469206564616d20;
   localparam logic [127:0] C_A = 128'ha65d985179783265_7860fedf5c570d18;
   localparam logic [127:0] K_B = 128'h1918_1110_0908_0100;
   localparam logic [127:0] P_B = 128'h6574_694c;
   localparam logic [127:0] C_B = 128'ha868_42f2;

   speck_cipher_core #(.WORD(64), .KEY_WORDS(2), .ROUNDS(T0)) u_speck128 (
      .clk(clk), .rst(rst), .start(start0), .decrypt(dec0), .key(key0),
      .block_in(blk0), .ready(ready0), .done(done0), .block_out(out0));

   speck_cipher_core #(.WORD(16), .KEY_WORDS(4), .ROUNDS(T1)) u_speck32 (
      .clk(clk), .rst(rst), .start(start1), .decrypt(dec1), .key(key1),
      .block_in(blk1), .ready(ready1), .done(done1), .block_out(out1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [63:0] rotr(input logic [63:0] v, input int s, input int n,
                                        input logic [63:0] mask);
      return ((v >> s) | (v << (n - s))) & mask;
   endfunction

   function automatic logic [63:0] rotl(input logic [63:0] v, input int s, input int n,
                                        input logic [63:0] mask);
      return ((v << s) | (v >> (n - s))) & mask;
   endfunction

   // Reference Speck encryption on n-bit words with an m-word key and t rounds.
   function automatic logic [127:0] model_enc(input int n, input int m, input int t,
                                              input logic [255:0] k, input logic [127:0] p);
      logic [63:0] mask, x, y;
      logic [63:0] rk [64];
      logic [63:0] l  [72];
      int a, b;
      a    = (n == 16) ? 7 : 8;
      b    = (n == 16) ? 2 : 3;
      mask = (n == 64) ? 64'hffff_ffff_ffff_ffff : ((64'd1 << n) - 64'd1);
      rk[0] = 64'(k) & mask;
      for (int j = 0; j < m - 1; j++) l[j] = 64'(k >> ((j + 1) * n)) & mask;
      for (int i = 0; i < t - 1; i++) begin
         l[i+m-1] = ((rk[i] + rotr(l[i], a, n, mask)) & mask) ^ 64'(i);
         rk[i+1]  = rotl(rk[i], b, n, mask) ^ l[i+m-1];
      end
      x = 64'(p >> n) & mask;
      y = 64'(p) & mask;
      for (int r = 0; r < t; r++) begin
         x = ((rotr(x, a, n, mask) + y) & mask) ^ rk[r];
         y = rotl(y, b, n, mask) ^ x;
      end
      return (128'(x) << n) | 128'(y);
   endfunction

   task automatic issue0(input logic [127:0] k, input logic [127:0] b, input logic d,
                         input logic [127:0] e, input bit hold);
      int w = 0;
      int lat;
      while (!ready0 && w < 400) begin @(negedge clk); w++; end
      check("ready0_wait", 128'(ready0), 128'(1));
      if (!ready0) return;
      start0 = 1'b1; key0 = k; blk0 = b; dec0 = d;
      lat = (c0_valid && c0_key == k) ? T0 + 1 : 2 * T0 + 1;
      c0_valid = 1'b1; c0_key = k;
      q0.push_back('{blk: e, cyc: cyc + 1 + lat});
      @(negedge clk);
      if (!hold) begin
         start0 = 1'b0; key0 = rnd128(); blk0 = rnd128(); dec0 = ~d;
      end
   endtask

   task automatic issue1(input logic [127:0] k, input logic [127:0] b, input logic d,
                         input logic [127:0] e);
      int w = 0;
      int lat;
      logic [127:0] r;
      while (!ready1 && w < 400) begin @(negedge clk); w++; end
      check("ready1_wait", 128'(ready1), 128'(1));
      if (!ready1) return;
      start1 = 1'b1; key1 = k[63:0]; blk1 = b[31:0]; dec1 = d;
      lat = (c1_valid && c1_key == k) ? T1 + 1 : 2 * T1 + 1;
      c1_valid = 1'b1; c1_key = k;
      q1.push_back('{blk: e, cyc: cyc + 1 + lat});
      @(negedge clk);
      r = rnd128();
      start1 = 1'b0; key1 = r[63:0]; blk1 = r[127:96]; dec1 = ~d;
   endtask

   task automatic drain();
      int w = 0;
      while ((q0.size() != 0 || q1.size() != 0) && w < 1000) begin @(negedge clk); w++; end
      check("drain", 128'(q0.size() + q1.size()), 128'(0));
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done0) begin
            check("done0_expected", 128'(q0.size() != 0), 128'(1));
            prev_done0 = last_done0;
            last_done0 = cyc;
            if (q0.size() != 0) begin
               e = q0.pop_front();
               check("block_out0", out0, e.blk);
               check("latency0", 128'(cyc), 128'(e.cyc));
            end
         end
         if (done1) begin
            check("done1_expected", 128'(q1.size() != 0), 128'(1));
            if (q1.size() != 0) begin
               e = q1.pop_front();
               check("block_out1", 128'(out1), e.blk);
               check("latency1", 128'(cyc), 128'(e.cyc));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [127:0] pool [3];
      logic [127:0] k, p, c, m64, m32;
      m64 = 128'hffff_ffff_ffff_ffff;
      m32 = 128'hffff_ffff;
      rst = 1'b0;
      start0 = 1'b0; dec0 = 1'b0; key0 = '0; blk0 = '0;
      start1 = 1'b0; dec1 = 1'b0; key1 = '0; blk1 = '0;
      repeat (3) @(negedge clk);
      check("reset_ready0", 128'(ready0), 128'(1));
      check("reset_done0", 128'(done0), 128'(0));
      check("reset_out0", out0, 128'(0));
      check("reset_ready1", 128'(ready1), 128'(1));
      check("reset_done1", 128'(done1), 128'(0));
      check("reset_out1", 128'(out1), 128'(0));
      rst = 1'b1;
      @(negedge clk);

      // Reference vectors: miss then hit, both key sizes.
      issue0(K_A, P_A, 1'b0, C_A, 1'b0);
      issue0(K_A, C_A, 1'b1, P_A, 1'b0);
      issue1(K_B, P_B, 1'b0, C_B);
      issue1(K_B, C_B, 1'b1, P_B);

      // start while busy with different key and block must be ignored.
      issue0(K_A, P_A, 1'b0, C_A, 1'b0);
      repeat (5) @(negedge clk);
      start0 = 1'b1; key0 = rnd128(); blk0 = rnd128(); dec0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;

      // start held high for two blocks.
      issue0(K_A, P_A, 1'b0, C_A, 1'b1);
      issue0(K_A, P_A, 1'b0, C_A, 1'b0);
      drain();
      check("b2b_spacing", 128'(last_done0 - prev_done0), 128'(T0 + 2));

      // Reset during RUN: no done, cache lost.
      issue0(K_A, P_A, 1'b0, C_A, 1'b0);
      repeat (9) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      q0.delete();
      q1.delete();
      c0_valid = 1'b0;
      c1_valid = 1'b0;
      check("abort_ready0", 128'(ready0), 128'(1));
      check("abort_out0", out0, 128'(0));
      check("abort_done0", 128'(done0), 128'(0));
      rst = 1'b1;
      repeat (80) @(negedge clk);
      issue0(K_A, P_A, 1'b0, C_A, 1'b0);

      pool[0] = K_A; pool[1] = rnd128(); pool[2] = rnd128();
      for (int i = 0; i < 12; i++) begin
         k = pool[$urandom_range(0, 2)];
         p = rnd128();
         c = model_enc(64, 2, T0, {128'h0, k}, p);
         if ($urandom_range(0, 1) == 1) issue0(k, c, 1'b1, p, 1'b0);
         else                           issue0(k, p, 1'b0, c, 1'b0);
      end

      pool[0] = K_B; pool[1] = rnd128() & m64; pool[2] = rnd128() & m64;
      for (int i = 0; i < 6; i++) begin
         k = pool[$urandom_range(0, 2)];
         p = rnd128() & m32;
         c = model_enc(16, 4, T1, {128'h0, k}, p);
         if ($urandom_range(0, 1) == 1) issue1(k, c, 1'b1, p);
         else                           issue1(k, p, 1'b0, c);
      end

      drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/speck_cipher_core.md
# speck_cipher_core

Parametrised iterative Speck block-cipher engine, one round per clock, with a start/done handshake and encrypt and decrypt modes. It generalises the fixed 128-bit single-mode encryptor in word width, key length and round count. It caches the expanded round keys so repeated operations under one key skip key expansion. It sits behind the host register interface, in the same position as the existing encryptor.

## Interface
- WORD, 64 — word width n in bits; the block is 2·WORD bits. Legal values: 16, 24, 32, 48, 64.
- KEY_WORDS, 2 — key length m in words; legal values 2–4. The key is KEY_WORDS·WORD bits.
- ROUNDS, 32 — number of rounds T; legal range 8–64.
- ALPHA/BETA — derived, not overridable: 7/2 when WORD=16, otherwise 8/3.
- clk  in  1  — sole clock; all logic is rising-edge.
- rst  in  1  — synchronous, active-low reset.
- start  in  1  — request; honoured only while ready=1.
- decrypt  in  1  — mode select, sampled with start: 0 = encrypt, 1 = decrypt.
- key  in  KEY_WORDS·WORD  — key, sampled with start. Word 0 (k0) is in the LSBs; l0..l(m-2) occupy the higher words.
- block_in  in  2·WORD  — input block, sampled with start. x is the upper word, y the lower word.
- ready  out  1  — high in IDLE.
- done  out  1  — one-cycle pulse; block_out is valid in the same cycle.
- block_out  out  2·WORD  — result; holds its value until the next done.

## Operation
- States: IDLE, EXPAND, RUN, DONE.
- IDLE → EXPAND on start when the key cache is invalid or key ≠ cached key.
- IDLE → RUN on start when the key cache is valid and key equals the cached key.
- start while not ready is ignored; the sampled inputs are not disturbed.
- EXPAND:
  - Runs T cycles and writes round keys rk[0..T-1] into a T×WORD register file.
  - rk[0] = k0.
  - l[i+m-1] = (rk[i] + ROR(l[i], ALPHA)) ^ i, where i is zero-extended to WORD.
  - rk[i+1] = ROL(rk[i], BETA) ^ l[i+m-1].
  - Each cycle handles one i; the l words shift through an (m-1)-deep register.
  - On exit, the cached key is set to the sampled key and the cache is marked valid. Next state is RUN.
- RUN, encrypt:
  - Runs T cycles with round index r = 0..T-1.
  - x ← (ROR(x, ALPHA) + y) ^ rk[r].
  - y ← ROL(y, BETA) ^ x_new.
- RUN, decrypt:
  - r runs T-1 down to 0.
  - y ← ROR(y ^ x, BETA).
  - x ← ROL((x ^ rk[r]) − y_new, ALPHA).
- Arithmetic: all additions and subtractions are modulo 2^WORD, with the carry/borrow discarded. Rotates are by constants within WORD bits.
- DONE: lasts one cycle. block_out ← {x, y}, done=1, then the FSM returns to IDLE.
- The round counter is clog2(ROUNDS) bits wide and clears on every state entry.
- A decrypt and an encrypt under the same key both reuse the cache; the mode does not affect cache validity.

## Timing
- Reset values (rst=0 at a clock edge):
  - state = IDLE, ready=1, done=0, block_out=0.
  - Cache invalidated; round counter = 0.
  - The round-key register file contents are don't-care.
- Reset asserted in any state aborts the operation with no done pulse.
- Cycle accounting, with start sampled at edge t0:
  - Cache hit: RUN occupies cycles t0+1..t0+T, DONE is at t0+T+1. done rises T+1 cycles after the start edge.
  - Cache miss: EXPAND occupies T cycles, then RUN T cycles. done rises 2T+1 cycles after the start edge.
- ready falls at t0+1 and returns to 1 in the cycle after DONE.
- start asserted in that same IDLE cycle begins a new operation, giving back-to-back throughput of T+2 cycles per block on a cache hit.
- start held high continuously re-triggers every T+2 cycles.
- Input changes after the start edge have no effect on the operation in flight.

## Test plan
- Speck128/128 (WORD=64, KEY_WORDS=2, ROUNDS=32):
  - Stimulus: key=0f0e0d0c0b0a0908_0706050403020100, block_in=6c61766975716520_7469206564616d20, encrypt.
  - Required: block_out=a65d985179783265_7860fedf5c570d18, with done exactly 65 cycles after start.
- Same key, decrypt that ciphertext → plaintext 6c61766975716520_7469206564616d20 is recovered, with done 33 cycles after start (cache hit).
- Speck32/64 (WORD=16, KEY_WORDS=4, ROUNDS=22):
  - Stimulus: key=1918_1110_0908_0100, block_in=6574_694c, encrypt.
  - Required: block_out=a868_42f2 at 45 cycles.
- Reset mid-run: assert rst=0 at RUN cycle 10 → done never pulses; next cycle ready=1, block_out=0. The following start with the same key takes 2T+1 cycles (cache invalid).
- start pulsed while busy, with a different block_in and key → ignored; result and latency are identical to the undisturbed run.
- Back-to-back: start held high for two blocks under one key → done pulses exactly T+2 cycles apart, and both outputs match the reference vectors.
